// File: rtl/energy_channel_averager.sv
// energy_channel_averager
//   Takes time-multiplexed samples from CHANNELS sensors and sums 2**AVG_LOG2 samples per
//   channel. It then emits each channel's block average through a one-entry valid/ready
//   output register. Each channel has an over-threshold alarm bit, and a sticky overrun
//   flag records any average that was dropped.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   ena                    block enable; when low, incoming samples are ignored
//   sample_in/ch/valid     sample input (channel index range-checked)
//   avg_out/ch/valid       averaged result, held stable while valid
//   avg_ready              consumer accepts avg_out
//   alarm[c]               last average of channel c exceeded THRESH
//   overrun, clr_overrun   sticky dropped-average flag and its synchronous clear
//
// Optional feature (macro ENERGY_AVG_PEAK_HOLD_EN):
//   peak_sel, peak_clr, peak_out -- per-channel running maximum of accepted raw samples.
module energy_channel_averager #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      CHANNELS = 4,
  parameter int unsigned      AVG_LOG2 = 2,
  parameter logic [WIDTH-1:0] THRESH   = 8'd200,
  localparam int unsigned     CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [WIDTH-1:0]    sample_in,
  input  logic [CW-1:0]       sample_ch,
  input  logic                sample_valid,
  output logic [WIDTH-1:0]    avg_out,
  output logic [CW-1:0]       avg_ch,
  output logic                avg_valid,
  input  logic                avg_ready,
  output logic [CHANNELS-1:0] alarm,
  output logic                overrun,
`ifdef ENERGY_AVG_PEAK_HOLD_EN
  input  logic [CW-1:0]       peak_sel,
  input  logic                peak_clr,
  output logic [WIDTH-1:0]    peak_out,
`endif
  input  logic                clr_overrun
);

  localparam int unsigned AW = WIDTH + AVG_LOG2;
  // Counter is kept at least 1 bit wide; with AVG_LOG2 == 0 it stays 0 and every sample is last.
  localparam int unsigned NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [NW-1:0] LastCnt = NW'((1 << AVG_LOG2) - 1);

  typedef enum logic {StEmpty, StFull} state_e;

  logic [AW-1:0]       acc_q [CHANNELS];
  logic [NW-1:0]       cnt_q [CHANNELS];
  state_e              state_q, state_d;
  logic [WIDTH-1:0]    avg_q;
  logic [CW-1:0]       ch_q;
  logic [CHANNELS-1:0] alarm_q;
  logic                overrun_q;

  logic                accept, last, done, load, ovr_set;
  logic [AW-1:0]       sum;
  logic [WIDTH-1:0]    avg_new;

  always_comb begin
    accept  = sample_valid && ena && (32'(sample_ch) < CHANNELS);
    sum     = acc_q[sample_ch] + AW'(sample_in);
    last    = (cnt_q[sample_ch] == LastCnt);
    done    = accept && last;
    avg_new = sum[AW-1:AVG_LOG2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else if (accept) begin
      if (last) begin
        acc_q[sample_ch] <= '0;
        cnt_q[sample_ch] <= '0;
      end else begin
        acc_q[sample_ch] <= sum;
        cnt_q[sample_ch] <= cnt_q[sample_ch] + NW'(1);
      end
    end
  end

  // Output register: a completion while full and not draining is dropped and flagged.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ovr_set = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (done) begin
          state_d = StFull;
          load    = 1'b1;
        end
      end
      StFull: begin
        if (avg_ready) begin
          if (done) load = 1'b1;
          else      state_d = StEmpty;
        end else if (done) begin
          ovr_set = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      avg_q     <= '0;
      ch_q      <= '0;
      alarm_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        avg_q <= avg_new;
        ch_q  <= sample_ch;
      end
      // Alarm tracks every completion, including dropped ones.
      if (done) alarm_q[sample_ch] <= (avg_new > THRESH);
      if (ovr_set)          overrun_q <= 1'b1;
      else if (clr_overrun) overrun_q <= 1'b0;
    end
  end

  assign avg_out   = avg_q;
  assign avg_ch    = ch_q;
  assign avg_valid = (state_q == StFull);
  assign alarm     = alarm_q;
  assign overrun   = overrun_q;

`ifdef ENERGY_AVG_PEAK_HOLD_EN
  logic [WIDTH-1:0] peak_q [CHANNELS];
  logic             peak_sel_ok;

  assign peak_sel_ok = (32'(peak_sel) < CHANNELS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < int'(CHANNELS); c++) peak_q[c] <= '0;
    end else begin
      if (peak_clr && peak_sel_ok) peak_q[peak_sel] <= '0;
      // A sample for the channel being cleared overrides the clear.
      if (accept && ((peak_clr && peak_sel == sample_ch) || sample_in > peak_q[sample_ch])) begin
        peak_q[sample_ch] <= sample_in;
      end
    end
  end

  assign peak_out = peak_sel_ok ? peak_q[peak_sel] : '0;
`endif

endmodule

// File: tb/tb_energy_channel_averager.sv
module tb_energy_channel_averager;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] sample_in;
  logic [1:0] sample_ch;
  logic       sample_valid;
  logic [7:0] avg_out;
  logic [1:0] avg_ch;
  logic       avg_valid;
  logic       avg_ready;
  logic [3:0] alarm;
  logic       overrun;
  logic       clr_overrun;
`ifdef ENERGY_AVG_PEAK_HOLD_EN
  logic [1:0] peak_sel;
  logic       peak_clr;
  logic [7:0] peak_out;
  logic [2:0] p2_sel;
  logic       p2_clr;
  logic [7:0] p2_out;
`endif

  // Second instance with a non-power-of-two channel count to reach out-of-range indices.
  logic [7:0] s2_in;
  logic [2:0] s2_ch;
  logic       s2_valid;
  logic [7:0] a2_out;
  logic [2:0] a2_ch;
  logic       a2_valid;
  logic [4:0] a2_alarm;
  logic       a2_overrun;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  energy_channel_averager dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .sample_in    (sample_in),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid),
    .avg_out      (avg_out),
    .avg_ch       (avg_ch),
    .avg_valid    (avg_valid),
    .avg_ready    (avg_ready),
    .alarm        (alarm),
    .overrun      (overrun),
`ifdef ENERGY_AVG_PEAK_HOLD_EN
    .peak_sel     (peak_sel),
    .peak_clr     (peak_clr),
    .peak_out     (peak_out),
`endif
    .clr_overrun  (clr_overrun)
  );

  energy_channel_averager #(.CHANNELS(5)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (1'b1),
    .sample_in    (s2_in),
    .sample_ch    (s2_ch),
    .sample_valid (s2_valid),
    .avg_out      (a2_out),
    .avg_ch       (a2_ch),
    .avg_valid    (a2_valid),
    .avg_ready    (1'b1),
    .alarm        (a2_alarm),
    .overrun      (a2_overrun),
`ifdef ENERGY_AVG_PEAK_HOLD_EN
    .peak_sel     (p2_sel),
    .peak_clr     (p2_clr),
    .peak_out     (p2_out),
`endif
    .clr_overrun  (1'b0)
  );

  // Inputs change on the falling edge; outputs are sampled on the falling edge too.
  task automatic drive(input logic v, input logic [1:0] ch, input logic [7:0] d);
    @(negedge clk);
    sample_valid = v;
    sample_ch    = ch;
    sample_in    = d;
  endtask

  task automatic drive2(input logic v, input logic [2:0] ch, input logic [7:0] d);
    @(negedge clk);
    s2_valid = v;
    s2_ch    = ch;
    s2_in    = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if (avg_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %0b want 0", avg_valid);
    end
    checks++;
    if (avg_out !== 8'd0 || avg_ch !== 2'd0) begin
      failures++; $display("FAIL reset_data: got out=%0d ch=%0d want 0/0", avg_out, avg_ch);
    end
    checks++;
    if (alarm !== 4'd0 || overrun !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got alarm=%b ovr=%b want 0000/0", alarm, overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    avg_ready = 1'b1;
    drive(1, 0, 8'd10);
    drive(1, 0, 8'd20);
    drive(1, 0, 8'd30);
    drive(1, 0, 8'd41);
    drive(0, 0, 8'd0);
    checks++;
    if (avg_valid !== 1'b1 || avg_ch !== 2'd0 || avg_out !== 8'd25) begin
      failures++;
      $display("FAIL basic_avg: got v=%0b ch=%0d out=%0d want 1/0/25", avg_valid, avg_ch, avg_out);
    end
    checks++;
    if (alarm[0] !== 1'b0) begin
      failures++; $display("FAIL basic_alarm: got %0b want 0", alarm[0]);
    end
    drive(0, 0, 8'd0);
    checks++;
    if (avg_valid !== 1'b0) begin
      failures++; $display("FAIL basic_drain: got %0b want 0", avg_valid);
    end
  endtask

  task automatic test_interleave;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 8'd250);
      drive(1, 2, 8'(i + 1));
    end
    drive(1, 1, 8'd250);
    drive(1, 2, 8'd4);
    checks++;
    if (avg_valid !== 1'b1 || avg_ch !== 2'd1 || avg_out !== 8'd250) begin
      failures++;
      $display("FAIL ilv_ch1: got v=%0b ch=%0d out=%0d want 1/1/250", avg_valid, avg_ch, avg_out);
    end
    checks++;
    if (alarm[1] !== 1'b1) begin
      failures++; $display("FAIL ilv_alarm1: got %0b want 1", alarm[1]);
    end
    drive(0, 0, 8'd0);
    checks++;
    if (avg_valid !== 1'b1 || avg_ch !== 2'd2 || avg_out !== 8'd2) begin
      failures++;
      $display("FAIL ilv_ch2: got v=%0b ch=%0d out=%0d want 1/2/2", avg_valid, avg_ch, avg_out);
    end
    checks++;
    if (alarm[2:1] !== 2'b01) begin
      failures++; $display("FAIL ilv_alarm2: got %b want 01", alarm[2:1]);
    end
  endtask

  task automatic test_overrun;
    @(negedge clk);
    avg_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(1, 0, 8'd100);
    for (int i = 0; i < 4; i++) drive(1, 3, 8'd40);
    drive(0, 0, 8'd0);
    checks++;
    if (avg_valid !== 1'b1 || avg_ch !== 2'd0 || avg_out !== 8'd100) begin
      failures++;
      $display("FAIL ovr_hold: got v=%0b ch=%0d out=%0d want 1/0/100", avg_valid, avg_ch, avg_out);
    end
    checks++;
    if (overrun !== 1'b1) begin
      failures++; $display("FAIL ovr_set: got %0b want 1", overrun);
    end
    checks++;
    if (alarm[3] !== 1'b0 || alarm[0] !== 1'b0) begin
      failures++; $display("FAIL ovr_alarm: got a3=%0b a0=%0b want 0/0", alarm[3], alarm[0]);
    end
    @(negedge clk);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0 || avg_valid !== 1'b1 || avg_out !== 8'd100) begin
      failures++;
      $display("FAIL ovr_clear: got ovr=%0b v=%0b out=%0d want 0/1/100", overrun, avg_valid, avg_out);
    end
    @(negedge clk);
    avg_ready = 1'b1;
    @(negedge clk);
    avg_ready = 1'b0;
    checks++;
    if (avg_valid !== 1'b0) begin
      failures++; $display("FAIL ovr_handshake: got %0b want 0", avg_valid);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) drive(1, 1, 8'd8);
    drive(0, 0, 8'd0);
    checks++;
    if (avg_valid !== 1'b1 || avg_ch !== 2'd1 || avg_out !== 8'd8 || alarm[1] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: got v=%0b ch=%0d out=%0d a1=%0b want 1/1/8/0",
               avg_valid, avg_ch, avg_out, alarm[1]);
    end
    for (int i = 0; i < 3; i++) drive(1, 3, 8'd12);
    drive(1, 3, 8'd12);
    avg_ready = 1'b1;
    drive(0, 0, 8'd0);
    avg_ready = 1'b0;
    checks++;
    if (avg_valid !== 1'b1 || avg_ch !== 2'd3 || avg_out !== 8'd12) begin
      failures++;
      $display("FAIL b2b_reload: got v=%0b ch=%0d out=%0d want 1/3/12", avg_valid, avg_ch, avg_out);
    end
    checks++;
    if (overrun !== 1'b0) begin
      failures++; $display("FAIL b2b_overrun: got %0b want 0", overrun);
    end
    @(negedge clk);
    avg_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (avg_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_drain: got %0b want 0", avg_valid);
    end
  endtask

  task automatic test_ena_reset;
    ena = 1'b0;
    for (int i = 0; i < 4; i++) drive(1, 0, 8'd50);
    drive(0, 0, 8'd0);
    ena = 1'b1;
    checks++;
    if (avg_valid !== 1'b0) begin
      failures++; $display("FAIL ena_low: got %0b want 0", avg_valid);
    end
    for (int i = 0; i < 2; i++) drive(1, 0, 8'd100);
    drive(0, 0, 8'd0);
    checks++;
    if (avg_valid !== 1'b0) begin
      failures++; $display("FAIL ena_partial: got %0b want 0", avg_valid);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (avg_valid !== 1'b0 || overrun !== 1'b0 || alarm !== 4'd0) begin
      failures++;
      $display("FAIL midreset: got v=%0b ovr=%0b alarm=%b want 0/0/0000", avg_valid, overrun, alarm);
    end
    for (int i = 0; i < 4; i++) drive(1, 0, 8'd8);
    drive(0, 0, 8'd0);
    checks++;
    if (avg_valid !== 1'b1 || avg_ch !== 2'd0 || avg_out !== 8'd8) begin
      failures++;
      $display("FAIL post_reset: got v=%0b ch=%0d out=%0d want 1/0/8", avg_valid, avg_ch, avg_out);
    end
  endtask

  task automatic test_out_of_range;
    for (int i = 0; i < 4; i++) drive2(1, 3'd5, 8'd99);
    for (int i = 0; i < 4; i++) drive2(1, 3'd7, 8'd99);
    drive2(0, 3'd0, 8'd0);
    checks++;
    if (a2_valid !== 1'b0 || a2_overrun !== 1'b0 || a2_alarm !== 5'd0) begin
      failures++;
      $display("FAIL oor_ignored: got v=%0b ovr=%0b alarm=%b want 0/0/00000",
               a2_valid, a2_overrun, a2_alarm);
    end
    for (int i = 0; i < 4; i++) drive2(1, 3'd4, 8'd60);
    drive2(0, 3'd0, 8'd0);
    checks++;
    if (a2_valid !== 1'b1 || a2_ch !== 3'd4 || a2_out !== 8'd60) begin
      failures++;
      $display("FAIL oor_valid_ch: got v=%0b ch=%0d out=%0d want 1/4/60", a2_valid, a2_ch, a2_out);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ena          = 1'b1;
    sample_in    = '0;
    sample_ch    = '0;
    sample_valid = 1'b0;
    avg_ready    = 1'b0;
    clr_overrun  = 1'b0;
    s2_in        = '0;
    s2_ch        = '0;
    s2_valid     = 1'b0;
`ifdef ENERGY_AVG_PEAK_HOLD_EN
    peak_sel = '0;
    peak_clr = 1'b0;
    p2_sel   = '0;
    p2_clr   = 1'b0;
`endif
    test_reset();
    test_basic();
    test_interleave();
    test_overrun();
    test_back_to_back();
    test_ena_reset();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
